// File: rtl/tx_seq_pkg.sv
// Shared command encodings, FSM state type and default widths for the
// transmit fire sequencer and its step table.
package tx_seq_pkg;

  localparam int DEF_NUM_CH = 8;
  localparam int DEF_NSTEPS = 16;
  localparam int DEF_PD_W   = 16;
  localparam int DEF_CT_W   = 9;
  localparam int DEF_GAP_W  = 16;
  localparam int DEF_REP_W  = 16;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_BUF  = 2'b01,
    CMD_FIRE = 2'b10,
    CMD_RST  = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    ST_CLR,
    ST_IDLE,
    ST_LOAD,
    ST_FIRE,
    ST_GAP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/tx_fire_sequencer_table.sv
// Step table: per-step {pd,ct} for every channel plus a tx mask, one write
// port and a registered read of a whole step onto the wide channel buses.
module tx_step_table
  import tx_seq_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int NSTEPS = DEF_NSTEPS,
  parameter int PD_W   = DEF_PD_W,
  parameter int CT_W   = DEF_CT_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        we,
  input  logic                        maskWe,
  input  logic [$clog2(NSTEPS)-1:0]   wrStep,
  input  logic [$clog2(NUM_CH)-1:0]   wrCh,
  input  logic [PD_W-1:0]             wrPd,
  input  logic [CT_W-1:0]             wrCt,
  input  logic [NUM_CH-1:0]           wrMask,
  input  logic                        rdEn,
  input  logic [$clog2(NSTEPS)-1:0]   rdStep,
  output logic [NUM_CH*PD_W-1:0]      rdPd,
  output logic [NUM_CH*CT_W-1:0]      rdCt,
  output logic [NUM_CH-1:0]           rdMask
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [PD_W-1:0]   pdMem   [NSTEPS][NUM_CH];
  logic [CT_W-1:0]   ctMem   [NSTEPS][NUM_CH];
  logic [NUM_CH-1:0] maskMem [NSTEPS];

  // Storage is deliberately not reset; only the read registers are.
  always_ff @(posedge clk) begin
    if (we) begin
      pdMem[wrStep][wrCh] <= wrPd;
      ctMem[wrStep][wrCh] <= wrCt;
    end
    if (maskWe) maskMem[wrStep] <= wrMask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPd   <= '0;
      rdCt   <= '0;
      rdMask <= '0;
    end else if (rdEn) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        rdPd[i*PD_W +: PD_W] <= pdMem[rdStep][CH_W'(i)];
        rdCt[i*CT_W +: CT_W] <= ctMem[rdStep][CH_W'(i)];
      end
      rdMask <= maskMem[rdStep];
    end
  end

endmodule

// File: rtl/tx_fire_sequencer.sv
// Steps a channel array through LOAD/FIRE/GAP for each programmed step and pass.
// Optional macro TXSEQ_WDOG_EN adds a FIRE watchdog and the wdog_err output.
module tx_fire_sequencer
  import tx_seq_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int NSTEPS = DEF_NSTEPS,
  parameter int PD_W   = DEF_PD_W,
  parameter int CT_W   = DEF_CT_W,
  parameter int GAP_W  = DEF_GAP_W,
  parameter int REP_W  = DEF_REP_W
`ifdef TXSEQ_WDOG_EN
  , parameter int WDOG_CYC = 2 ** (PD_W + 1)
`endif
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_we,
  input  logic                        cfg_mask_we,
  input  logic [$clog2(NSTEPS)-1:0]   cfg_step,
  input  logic [$clog2(NUM_CH)-1:0]   cfg_ch,
  input  logic [PD_W-1:0]             cfg_pd,
  input  logic [CT_W-1:0]             cfg_ct,
  input  logic [NUM_CH-1:0]           cfg_mask,
  input  logic [$clog2(NSTEPS):0]     num_steps,
  input  logic [REP_W-1:0]            num_reps,
  input  logic [GAP_W-1:0]            gap_cycles,
  input  logic                        start,
  input  logic                        abort,
  input  logic [NUM_CH-1:0]           ch_active,
  output logic [1:0]                  ch_cmd,
  output logic [NUM_CH*PD_W-1:0]      ch_pd,
  output logic [NUM_CH*CT_W-1:0]      ch_ct,
  output logic [NUM_CH-1:0]           ch_mask,
  output logic                        busy,
  output logic                        done,
  output logic                        aborted,
  output logic                        cfg_rej,
  output logic [$clog2(NSTEPS)-1:0]   cur_step
`ifdef TXSEQ_WDOG_EN
  , output logic                      wdog_err
`endif
);

  localparam int STEP_W = $clog2(NSTEPS);

  state_t             state;
  logic               loadCnt;
  logic [1:0]         fireCnt;
  logic [GAP_W-1:0]   gapCnt, gapR;
  logic [STEP_W:0]    stepCnt, numStepsR;
  logic [REP_W-1:0]   repCnt, numRepsR;
  logic               idle, rdEn, gapEnd, wdogHit;

  assign idle     = (state == ST_IDLE);
  assign rdEn     = (state == ST_LOAD) && !loadCnt;
  assign gapEnd   = ({1'b0, gapCnt} + 1'b1) >= {1'b0, gapR};
  assign cur_step = stepCnt[STEP_W-1:0];

  tx_step_table #(
    .NUM_CH (NUM_CH),
    .NSTEPS (NSTEPS),
    .PD_W   (PD_W),
    .CT_W   (CT_W)
  ) u_table (
    .clk    (clk),
    .reset  (reset),
    .we     (cfg_we & idle),
    .maskWe (cfg_mask_we & idle),
    .wrStep (cfg_step),
    .wrCh   (cfg_ch),
    .wrPd   (cfg_pd),
    .wrCt   (cfg_ct),
    .wrMask (cfg_mask),
    .rdEn   (rdEn),
    .rdStep (cur_step),
    .rdPd   (ch_pd),
    .rdCt   (ch_ct),
    .rdMask (ch_mask)
  );

`ifdef TXSEQ_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC) + 1;
  logic [WD_W-1:0] wdogCnt;

  assign wdogHit = (state == ST_FIRE) && (wdogCnt == WD_W'(WDOG_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wdogCnt  <= '0;
      wdog_err <= 1'b0;
    end else begin
      wdogCnt <= (state == ST_FIRE) ? wdogCnt + 1'b1 : '0;
      if (wdogHit)            wdog_err <= 1'b1;
      else if (idle && start) wdog_err <= 1'b0;
    end
  end
`else
  assign wdogHit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_CLR;
      ch_cmd    <= CMD_NOP;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      cfg_rej   <= 1'b0;
      loadCnt   <= 1'b0;
      fireCnt   <= '0;
      gapCnt    <= '0;
      gapR      <= '0;
      stepCnt   <= '0;
      numStepsR <= '0;
      repCnt    <= '0;
      numRepsR  <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      cfg_rej <= (cfg_we | cfg_mask_we) & ~idle;
      if (!idle && (abort || wdogHit)) begin
        state   <= ST_CLR;
        ch_cmd  <= CMD_RST;
        busy    <= 1'b1;
        aborted <= 1'b1;
      end else begin
        case (state)
          // Leaving reset, CLR first spends a cycle raising the reset command,
          // so the channels always see exactly one 11 before IDLE.
          ST_CLR: begin
            if (ch_cmd == CMD_RST) begin
              state  <= ST_IDLE;
              ch_cmd <= CMD_NOP;
              busy   <= 1'b0;
            end else begin
              ch_cmd <= CMD_RST;
              busy   <= 1'b1;
            end
          end
          ST_IDLE: begin
            if (start && !abort) begin
              if (num_steps == '0) begin
                done <= 1'b1;
              end else begin
                state     <= ST_LOAD;
                ch_cmd    <= CMD_BUF;
                busy      <= 1'b1;
                loadCnt   <= 1'b0;
                stepCnt   <= '0;
                repCnt    <= '0;
                numStepsR <= num_steps;
                numRepsR  <= (num_reps == '0) ? REP_W'(1) : num_reps;
                gapR      <= gap_cycles;
              end
            end
          end
          ST_LOAD: begin
            if (!loadCnt) begin
              loadCnt <= 1'b1;
            end else begin
              state   <= ST_FIRE;
              ch_cmd  <= CMD_FIRE;
              fireCnt <= '0;
            end
          end
          ST_FIRE: begin
            if (fireCnt != 2'd2) begin
              fireCnt <= fireCnt + 1'b1;
            end else if (ch_active == '0) begin
              state  <= ST_GAP;
              ch_cmd <= CMD_BUF;
              gapCnt <= '0;
            end
          end
          ST_GAP: begin
            if (!gapEnd) begin
              gapCnt <= gapCnt + 1'b1;
            end else if ((stepCnt + 1'b1) < numStepsR) begin
              state   <= ST_LOAD;
              loadCnt <= 1'b0;
              stepCnt <= stepCnt + 1'b1;
            end else if (({1'b0, repCnt} + 1'b1) < {1'b0, numRepsR}) begin
              state   <= ST_LOAD;
              loadCnt <= 1'b0;
              stepCnt <= '0;
              repCnt  <= repCnt + 1'b1;
            end else begin
              state  <= ST_DONE;
              ch_cmd <= CMD_NOP;
              done   <= 1'b1;
            end
          end
          ST_DONE: begin
            state  <= ST_CLR;
            ch_cmd <= CMD_RST;
          end
          default: begin
            state  <= ST_CLR;
            ch_cmd <= CMD_RST;
            busy   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_fire_sequencer.sv
// Directed and randomized bench for tx_fire_sequencer against a per-cycle
// expected command trace derived from the step table contents.
`timescale 1ns/1ps
module tb_tx_fire_sequencer;
  import tx_seq_pkg::*;

  localparam int NCH = 8, NST = 16, PDW = 16, CTW = 9, GW = 16, RW = 16;
  localparam int SW = 4, CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, cfg_we, cfg_mask_we, start, abort;
  logic [SW-1:0] cfg_step;
  logic [CW-1:0] cfg_ch;
  logic [PDW-1:0] cfg_pd;
  logic [CTW-1:0] cfg_ct;
  logic [NCH-1:0] cfg_mask, ch_active, ch_mask;
  logic [SW:0] num_steps;
  logic [RW-1:0] num_reps;
  logic [GW-1:0] gap_cycles;
  logic [1:0] ch_cmd;
  logic [NCH*PDW-1:0] ch_pd;
  logic [NCH*CTW-1:0] ch_ct;
  logic busy, done, aborted, cfg_rej;
  logic [SW-1:0] cur_step;
  logic wdog_err;

`ifdef TXSEQ_WDOG_EN
  tx_fire_sequencer #(
    .NUM_CH   (NCH),
    .NSTEPS   (NST),
    .PD_W     (PDW),
    .CT_W     (CTW),
    .GAP_W    (GW),
    .REP_W    (RW),
    .WDOG_CYC (64)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_mask_we(cfg_mask_we),
    .cfg_step(cfg_step), .cfg_ch(cfg_ch), .cfg_pd(cfg_pd), .cfg_ct(cfg_ct),
    .cfg_mask(cfg_mask), .num_steps(num_steps), .num_reps(num_reps),
    .gap_cycles(gap_cycles), .start(start), .abort(abort), .ch_active(ch_active),
    .ch_cmd(ch_cmd), .ch_pd(ch_pd), .ch_ct(ch_ct), .ch_mask(ch_mask),
    .busy(busy), .done(done), .aborted(aborted), .cfg_rej(cfg_rej),
    .cur_step(cur_step), .wdog_err(wdog_err)
  );
`else
  assign wdog_err = 1'b0;

  tx_fire_sequencer #(
    .NUM_CH (NCH),
    .NSTEPS (NST),
    .PD_W   (PDW),
    .CT_W   (CTW),
    .GAP_W  (GW),
    .REP_W  (RW)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_mask_we(cfg_mask_we),
    .cfg_step(cfg_step), .cfg_ch(cfg_ch), .cfg_pd(cfg_pd), .cfg_ct(cfg_ct),
    .cfg_mask(cfg_mask), .num_steps(num_steps), .num_reps(num_reps),
    .gap_cycles(gap_cycles), .start(start), .abort(abort), .ch_active(ch_active),
    .ch_cmd(ch_cmd), .ch_pd(ch_pd), .ch_ct(ch_ct), .ch_mask(ch_mask),
    .busy(busy), .done(done), .aborted(aborted), .cfg_rej(cfg_rej),
    .cur_step(cur_step)
  );
`endif

  int total = 0, bad = 0;
  int mdlPd [NST][NCH];
  int mdlCt [NST][NCH];
  logic [NCH-1:0] mdlMask [NST];

  typedef struct {
    logic [1:0] cmd;
    int step;
    bit chkStep;
    bit fire;
    bit done;
    bit busy;
    bit abt;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wrCell(input int s, input int c, input int pd, input int ct);
    cfg_we = 1'b1; cfg_step = SW'(s); cfg_ch = CW'(c);
    cfg_pd = PDW'(pd); cfg_ct = CTW'(ct);
    mdlPd[s][c] = pd; mdlCt[s][c] = ct;
    tick();
    cfg_we = 1'b0;
    chk("rej_idle", cfg_rej, 0);
  endtask

  task automatic wrMask(input int s, input logic [NCH-1:0] m);
    cfg_mask_we = 1'b1; cfg_step = SW'(s); cfg_mask = m;
    mdlMask[s] = m;
    tick();
    cfg_mask_we = 1'b0;
  endtask

  function automatic int lastActive(input int s, input int c);
    if (mdlMask[s][c] && mdlCt[s][c] != 0) return 1 + mdlPd[s][c] + mdlCt[s][c];
    return 0;
  endfunction

  function automatic int fireLen(input int s);
    int l = 0;
    for (int c = 0; c < NCH; c++) if (lastActive(s, c) > l) l = lastActive(s, c);
    return (l + 1 > 3) ? l + 1 : 3;
  endfunction

  function automatic logic [NCH*PDW-1:0] expPd(input int s);
    logic [NCH*PDW-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*PDW +: PDW] = PDW'(mdlPd[s][c]);
    return v;
  endfunction

  function automatic logic [NCH*CTW-1:0] expCt(input int s);
    logic [NCH*CTW-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*CTW +: CTW] = CTW'(mdlCt[s][c]);
    return v;
  endfunction

  task automatic buildTrace(input int ns, input int nr, input int gap);
    int reps = (nr == 0) ? 1 : nr;
    int glen = (gap == 0) ? 1 : gap;
    q.delete();
    for (int r = 0; r < reps; r++)
      for (int s = 0; s < ns; s++) begin
        for (int k = 0; k < 2; k++) q.push_back('{CMD_BUF, s, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        for (int k = 0; k < fireLen(s); k++) q.push_back('{CMD_FIRE, s, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        for (int k = 0; k < glen; k++) q.push_back('{CMD_BUF, s, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
      end
    q.push_back('{CMD_NOP, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    q.push_back('{CMD_RST, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    q.push_back('{CMD_NOP, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic runSeq(input int ns, input int nr, input int gap,
                        input int abortAfter, input int rejAt, input bit wrOnStart);
    int fk = 0, aIdx = -1, s, c;
    exp_t e;
    num_steps = (SW+1)'(ns); num_reps = RW'(nr); gap_cycles = GW'(gap);
    start = 1'b1;
    if (wrOnStart) begin
      s = $urandom_range(0, ns - 1); c = $urandom_range(0, NCH - 1);
      cfg_we = 1'b1; cfg_step = SW'(s); cfg_ch = CW'(c);
      mdlPd[s][c] = $urandom_range(0, 3); mdlCt[s][c] = $urandom_range(1, 6);
      cfg_pd = PDW'(mdlPd[s][c]); cfg_ct = CTW'(mdlCt[s][c]);
    end
    buildTrace(ns, nr, gap);
    if (abortAfter >= 0) begin
      for (int i = 0; i < q.size(); i++) if (q[i].fire && aIdx < 0) aIdx = i + abortAfter;
      while (q.size() > aIdx + 1) void'(q.pop_back());
      q.push_back('{CMD_RST, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
      q.push_back('{CMD_NOP, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    tick();
    start = 1'b0; cfg_we = 1'b0;
    num_steps = (SW+1)'($urandom_range(0, 16));
    num_reps = RW'($urandom_range(0, 9));
    gap_cycles = GW'($urandom_range(0, 9));
    for (int i = 0; i < q.size(); i++) begin
      e = q[i];
      chk("cmd", ch_cmd, e.cmd);
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      chk("aborted", aborted, e.abt);
      chk("cfg_rej", cfg_rej, (rejAt >= 0 && i == rejAt + 1));
      if (e.chkStep) chk("cur_step", cur_step, e.step);
      if (e.fire) begin
        chk("ch_pd", ch_pd, expPd(e.step));
        chk("ch_ct", ch_ct, expCt(e.step));
        chk("ch_mask", ch_mask, mdlMask[e.step]);
      end
      fk = e.fire ? fk + 1 : 0;
      ch_active = '0;
      if (e.fire)
        for (int k = 0; k < NCH; k++)
          if (fk >= 2 && fk <= lastActive(e.step, k)) ch_active[k] = 1'b1;
      if (i == aIdx) begin abort = 1'b1; ch_active = '1; end
      if (i == rejAt) begin
        cfg_we = 1'b1; cfg_step = '0; cfg_ch = '0;
        cfg_pd = PDW'(mdlPd[0][0] + 7); cfg_ct = CTW'(mdlCt[0][0] + 3);
      end
      tick();
      abort = 1'b0; cfg_we = 1'b0; ch_active = '0;
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; cfg_we = 0; cfg_mask_we = 0; start = 0; abort = 0;
    cfg_step = '0; cfg_ch = '0; cfg_pd = '0; cfg_ct = '0; cfg_mask = '0;
    num_steps = '0; num_reps = '0; gap_cycles = '0; ch_active = '0;
    repeat (3) tick();
    chk("rst_cmd", ch_cmd, 0);
    chk("rst_pd", ch_pd, 0);
    chk("rst_ct", ch_ct, 0);
    chk("rst_mask", ch_mask, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_cfg_rej", cfg_rej, 0);
    chk("rst_cur_step", cur_step, 0);
    reset = 1'b0;
    tick();
    chk("clr_cmd", ch_cmd, CMD_RST);
    tick();
    chk("idle_cmd", ch_cmd, CMD_NOP);
    chk("idle_busy", busy, 0);

    for (int s = 0; s < NST; s++) begin
      for (int c = 0; c < NCH; c++) wrCell(s, c, $urandom_range(0, 3), $urandom_range(0, 6));
      wrMask(s, NCH'($urandom));
    end

    wrCell(0, 0, 3, 4);
    wrMask(0, 8'h01);
    runSeq(1, 1, 0, -1, -1, 1'b0);
    runSeq(3, 2, 5, -1, -1, 1'b0);
    runSeq(2, 1, 1, -1, 3, 1'b0);
    runSeq(1, 1, 0, -1, -1, 1'b0);
    wrMask(1, 8'hFF);
    runSeq(2, 1, 2, 1, -1, 1'b0);
    runSeq(2, 0, 0, -1, -1, 1'b1);
    runSeq(NST, 1, 0, -1, -1, 1'b0);

    for (int it = 0; it < 6; it++) begin
      repeat (3) wrCell($urandom_range(0, 4), $urandom_range(0, NCH - 1),
                        $urandom_range(0, 3), $urandom_range(0, 6));
      wrMask($urandom_range(0, 4), NCH'($urandom));
      runSeq($urandom_range(1, 5), $urandom_range(0, 2), $urandom_range(0, 4),
             (it == 4) ? int'($urandom_range(0, 2)) : -1,
             (it == 2) ? int'($urandom_range(0, 4)) : -1,
             1'(it % 2));
    end

    num_steps = '0; num_reps = RW'(1); start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_cmd", ch_cmd, CMD_NOP);
    chk("zero_busy", busy, 0);
    repeat (2) begin
      tick();
      chk("zero_done_after", done, 0);
      chk("zero_cmd_after", ch_cmd, CMD_NOP);
    end

    num_steps = (SW+1)'(2); start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (3) begin
      chk("abst_cmd", ch_cmd, CMD_NOP);
      chk("abst_busy", busy, 0);
      chk("abst_aborted", aborted, 0);
      chk("abst_done", done, 0);
      tick();
    end

`ifdef TXSEQ_WDOG_EN
    begin
      int fires = 0;
      wrMask(0, '1);
      num_steps = (SW+1)'(1); num_reps = RW'(1); gap_cycles = '0; start = 1'b1;
      tick();
      start = 1'b0; ch_active = '1;
      for (int i = 0; i < 200 && ch_cmd != CMD_RST; i++) begin
        if (ch_cmd == CMD_FIRE) fires++;
        tick();
      end
      chk("wdog_fire_len", fires, 64);
      chk("wdog_cmd", ch_cmd, CMD_RST);
      chk("wdog_aborted", aborted, 1);
      chk("wdog_err", wdog_err, 1);
      ch_active = '0;
      tick();
      chk("wdog_busy", busy, 0);
      chk("wdog_err_sticky", wdog_err, 1);
      num_steps = '0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("wdog_err_clr", wdog_err, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
